// File: rtl/encoder_priority_arbiter_n_pkg.sv
// Shared types and helpers for the registered priority encoder/arbiter.
// Widest request vector the onehot helper can produce is MAX_N.
package encoder_pkg;

    localparam int MAX_N = 64;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    function automatic logic [MAX_N-1:0] onehot(input int idx);
        return MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/encoder_priority_arbiter_n_priority_select.sv
// Combinational wrap-around search: walks the pending vector downward from
// i_start, wrapping from index 0 to N-1, and reports the first set bit.
module priority_select #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] i_pending,
    input  logic [W-1:0] i_start,
    output logic [W-1:0] o_index,
    output logic         o_found
);

    int w_j;

    // Only the first hit along the search order is kept.
    always_comb begin
        o_index = '0;
        o_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(i_start) - k;
            if (w_j < 0) begin
                w_j = w_j + N;
            end
            if (!o_found && i_pending[w_j]) begin
                o_index = W'(w_j);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_priority_arbiter_n.sv
// Registered N-input active-low priority encoder with fixed or round-robin
// arbitration, a valid/ack grant handshake and chainable cascade outputs.
module encoder_priority_arbiter_n
    import encoder_pkg::*;
#(
    parameter  int N         = 8,
    parameter  int EDGE_MODE = 0,
    localparam int W         = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable_in_,
    input  logic [N-1:0] req_i_,
    input  logic         rr_mode,
    input  logic         ack_i,
    output logic [W-1:0] code_o,
    output logic         valid_o,
    output logic [N-1:0] pending_o,
    output logic         group_signal_,
    output logic         enable_out_
);

    logic [N-1:0] r_smp;
    logic [N-1:0] r_smpD;
    logic [W-1:0] r_ptr;
    state_t       r_state;

    logic [N-1:0] w_set;
    logic [N-1:0] w_clr;
    logic         w_accept;
    logic [W-1:0] w_start;
    logic [W-1:0] w_winner;
    logic         w_found;

    assign w_accept = valid_o & ack_i & ~enable_in_;
    assign w_clr    = w_accept ? N'(onehot(int'(code_o))) : '0;
    assign w_start  = rr_mode ? r_ptr : W'(N - 1);

    // Edge mode only sets a bit on the cycle the request first goes low.
    always_comb begin
        w_set = '0;
        if (!enable_in_) begin
            w_set = (EDGE_MODE != 0) ? (r_smp & ~r_smpD) : r_smp;
        end
    end

    priority_select #(.N(N)) u_select (
        .i_pending (pending_o),
        .i_start   (w_start),
        .o_index   (w_winner),
        .o_found   (w_found)
    );

    // A bit set in the same cycle it is acknowledged stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp     <= '0;
            r_smpD    <= '0;
            pending_o <= '0;
            r_ptr     <= W'(N - 1);
        end else begin
            r_smp     <= ~req_i_;
            r_smpD    <= r_smp;
            pending_o <= (pending_o & ~w_clr) | w_set;
            if (w_accept && rr_mode) begin
                r_ptr <= (code_o == '0) ? W'(N - 1) : code_o - W'(1);
            end
        end
    end

    // Once offered, a grant is held until accepted or withdrawn by disable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            code_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!enable_in_ && w_found) begin
                        code_o  <= w_winner;
                        valid_o <= 1'b1;
                        r_state <= OFFER;
                    end
                end
                OFFER: begin
                    if (enable_in_ || ack_i) begin
                        valid_o <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            group_signal_ <= 1'b1;
            enable_out_   <= 1'b1;
        end else begin
            group_signal_ <= ~(~enable_in_ & (|pending_o));
            enable_out_   <= ~(~enable_in_ & ~(|pending_o) & ~valid_o);
        end
    end

endmodule

// File: tb/tb_encoder_priority_arbiter_n.sv
// Bench for encoder_priority_arbiter_n: table vectors, directed corner cases
// and a randomized run against an array-based reference model.
module tb_encoder_priority_arbiter_n;

    logic clk;
    logic rst;

    logic       enA, rrA, ackA;
    logic [7:0] reqA;
    logic [2:0] codeA;
    logic       validA, groupA, eoA;
    logic [7:0] pendA;

    logic       ackB;
    logic [7:0] reqB;
    logic [2:0] codeB;
    logic       validB, groupB, eoB;
    logic [7:0] pendB;

    logic       rrC, ackC;
    logic [4:0] reqC;
    logic [2:0] codeC;
    logic       validC, groupC, eoC;
    logic [4:0] pendC;

    logic enBC;
    logic rrB;

    int checks;
    int errors;
    int gotCodes[8];
    int gotN;
    bit ok;
    bit cmpOn;

    typedef struct {
        logic [7:0] req;
        logic       ack;
        logic [7:0] expPend;
        logic       expValid;
        logic [2:0] expCode;
        logic       expGroup;
        logic       expEo;
    } vec_t;

    vec_t vecs[10];

    encoder_priority_arbiter_n #(.N(8), .EDGE_MODE(0)) dutA (
        .clk(clk), .rst(rst), .enable_in_(enA), .req_i_(reqA), .rr_mode(rrA),
        .ack_i(ackA), .code_o(codeA), .valid_o(validA), .pending_o(pendA),
        .group_signal_(groupA), .enable_out_(eoA)
    );

    encoder_priority_arbiter_n #(.N(8), .EDGE_MODE(1)) dutB (
        .clk(clk), .rst(rst), .enable_in_(enBC), .req_i_(reqB), .rr_mode(rrB),
        .ack_i(ackB), .code_o(codeB), .valid_o(validB), .pending_o(pendB),
        .group_signal_(groupB), .enable_out_(eoB)
    );

    encoder_priority_arbiter_n #(.N(5), .EDGE_MODE(0)) dutC (
        .clk(clk), .rst(rst), .enable_in_(enBC), .req_i_(reqC), .rr_mode(rrC),
        .ack_i(ackC), .code_o(codeC), .valid_o(validC), .pending_o(pendC),
        .group_signal_(groupC), .enable_out_(eoC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model for dutA: arrays of pending flags and a plain search.
    bit mPend[8];
    bit mSmp[8];
    bit mNext[8];
    int mCode;
    bit mValid;
    int mPtr;
    bit mGroup;
    bit mEo;
    bit mEn, mAcc, mAny;
    int mStart, mPick, mIdx;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                mPend[i] = 1'b0;
                mSmp[i]  = 1'b0;
            end
            mCode = 0; mValid = 1'b0; mPtr = 7; mGroup = 1'b1; mEo = 1'b1;
        end else begin
            mEn  = !enA;
            mAcc = mValid && ackA && mEn;
            mAny = 1'b0;
            for (int i = 0; i < 8; i++) mAny = mAny | mPend[i];
            for (int i = 0; i < 8; i++)
                mNext[i] = (mPend[i] && !(mAcc && mCode == i)) || (mEn && mSmp[i]);
            mGroup = !(mEn && mAny);
            mEo    = !(mEn && !mAny && !mValid);
            if (mAcc && rrA) mPtr = (mCode + 7) % 8;
            if (mValid) begin
                if (!mEn || ackA) mValid = 1'b0;
            end else if (mEn && mAny) begin
                mStart = rrA ? mPtr : 7;
                mPick  = -1;
                for (int k = 0; k < 8; k++) begin
                    mIdx = (mStart - k + 8) % 8;
                    if (mPick < 0 && mPend[mIdx]) mPick = mIdx;
                end
                mCode  = mPick;
                mValid = 1'b1;
            end
            for (int i = 0; i < 8; i++) begin
                mPend[i] = mNext[i];
                mSmp[i]  = !reqA[i];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitValidA(input int maxCyc, input string name);
        ok = 1'b0;
        for (int c = 0; c < maxCyc; c++) begin
            if (validA) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic collectA(input int want, input int maxCyc);
        gotN = 0;
        for (int i = 0; i < 8; i++) gotCodes[i] = 99;
        for (int c = 0; c < maxCyc; c++) begin
            @(negedge clk);
            if (validA && gotN < want) begin
                gotCodes[gotN] = int'(codeA);
                gotN++;
            end
            if (gotN == want) break;
        end
    endtask

    task automatic collectC(input int want, input int maxCyc);
        gotN = 0;
        for (int i = 0; i < 8; i++) gotCodes[i] = 99;
        for (int c = 0; c < maxCyc; c++) begin
            @(negedge clk);
            if (validC && gotN < want) begin
                gotCodes[gotN] = int'(codeC);
                gotN++;
            end
            if (gotN == want) break;
        end
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, "_pend"},  32'(pendA),   32'h0);
        checkOutput({tag, "_valid"}, 32'(validA),  32'h0);
        checkOutput({tag, "_code"},  32'(codeA),   32'h0);
        checkOutput({tag, "_group"}, 32'(groupA),  32'h1);
        checkOutput({tag, "_eo"},    32'(eoA),     32'h1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: got running, wanted finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int cntB;
        checks = 0; errors = 0; cmpOn = 1'b0;
        rst = 1'b1; enA = 1'b0; rrA = 1'b0; ackA = 1'b0; reqA = 8'h00;
        ackB = 1'b0; reqB = 8'hFF; rrC = 1'b0; ackC = 1'b0; reqC = 5'h1F;
        enBC = 1'b0; rrB = 1'b0;

        vecs[0] = '{8'hAB, 1'b1, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 8'h54, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 8'h54, 1'b1, 3'd6, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 8'h14, 1'b0, 3'd6, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 8'h14, 1'b1, 3'd4, 1'b0, 1'b1};
        vecs[5] = '{8'hFF, 1'b1, 8'h04, 1'b0, 3'd4, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 1'b1, 8'h04, 1'b1, 3'd2, 1'b0, 1'b1};
        vecs[7] = '{8'hFF, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0, 1'b1};
        vecs[8] = '{8'hFF, 1'b1, 8'h00, 1'b0, 3'd2, 1'b1, 1'b0};
        vecs[9] = '{8'hFF, 1'b1, 8'h00, 1'b0, 3'd2, 1'b1, 1'b0};

        // Reset with every request asserted.
        applyStimulus(2);
        checkResetA("reset");
        rst = 1'b0; reqA = 8'hFF;
        applyStimulus(1);

        // Fixed priority, level capture: 8'hAB pulse grants 6, 4, 2.
        for (int i = 0; i < 10; i++) begin
            reqA = vecs[i].req;
            ackA = vecs[i].ack;
            applyStimulus(1);
            checkOutput($sformatf("fixed%0d_pend", i),  32'(pendA),  32'(vecs[i].expPend));
            checkOutput($sformatf("fixed%0d_valid", i), 32'(validA), 32'(vecs[i].expValid));
            checkOutput($sformatf("fixed%0d_code", i),  32'(codeA),  32'(vecs[i].expCode));
            checkOutput($sformatf("fixed%0d_group", i), 32'(groupA), 32'(vecs[i].expGroup));
            checkOutput($sformatf("fixed%0d_eo", i),    32'(eoA),    32'(vecs[i].expEo));
        end

        // Round-robin alternates between held bits 7 and 1.
        rrA = 1'b1; reqA = 8'h7D; ackA = 1'b1;
        collectA(4, 30);
        checkOutput("rr_count", 32'(gotN), 32'd4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("rr_code%0d", i), 32'(gotCodes[i]), (i % 2 == 0) ? 32'd7 : 32'd1);
        reqA = 8'hFF;
        applyStimulus(12);

        rrA = 1'b0; reqA = 8'h7D;
        collectA(3, 30);
        checkOutput("fixed_hold_count", 32'(gotN), 32'd3);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("fixed_hold_code%0d", i), 32'(gotCodes[i]), 32'd7);
        reqA = 8'hFF;
        applyStimulus(12);

        // Outstanding grant of 2 is not preempted by a later bit 7.
        ackA = 1'b0; reqA = 8'hFB;
        applyStimulus(1);
        reqA = 8'hFF;
        waitValidA(6, "hold_grant");
        checkOutput("hold_first_code", 32'(codeA), 32'd2);
        reqA = 8'h7F;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1);
            reqA = 8'hFF;
            checkOutput($sformatf("hold%0d_valid", i), 32'(validA), 32'd1);
            checkOutput($sformatf("hold%0d_code", i),  32'(codeA),  32'd2);
        end
        ackA = 1'b1;
        applyStimulus(1);
        ackA = 1'b0;
        checkOutput("hold_ack_valid", 32'(validA), 32'd0);
        applyStimulus(1);
        checkOutput("hold_next_valid", 32'(validA), 32'd1);
        checkOutput("hold_next_code",  32'(codeA),  32'd7);
        ackA = 1'b1;
        applyStimulus(1);
        ackA = 1'b0;
        applyStimulus(1);

        // Disable during an offer withdraws it without touching pending.
        reqA = 8'hDF;
        applyStimulus(1);
        reqA = 8'hFF;
        waitValidA(6, "en_grant");
        checkOutput("en_first_code", 32'(codeA), 32'd5);
        enA = 1'b1; ackA = 1'b1;
        applyStimulus(1);
        checkOutput("en_off_valid", 32'(validA), 32'd0);
        checkOutput("en_off_pend",  32'(pendA),  32'h20);
        enA = 1'b0; ackA = 1'b0;
        applyStimulus(1);
        checkOutput("en_reoffer_valid", 32'(validA), 32'd1);
        checkOutput("en_reoffer_code",  32'(codeA),  32'd5);
        checkOutput("en_reoffer_pend",  32'(pendA),  32'h20);
        ackA = 1'b1;
        applyStimulus(1);
        ackA = 1'b0;
        checkOutput("en_done_pend", 32'(pendA), 32'h00);

        // Reset while a grant is outstanding.
        reqA = 8'hEF;
        applyStimulus(1);
        reqA = 8'hFF;
        waitValidA(6, "rst_grant");
        rst = 1'b1;
        applyStimulus(1);
        checkResetA("rst_offer");
        rst = 1'b0;
        applyStimulus(1);

        // Edge capture: a long assertion yields a single grant.
        ackB = 1'b1; reqB = 8'hF7; cntB = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1);
            if (validB) begin
                cntB++;
                checkOutput("edge1_code", 32'(codeB), 32'd3);
            end
        end
        reqB = 8'hFF;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1);
            if (validB) cntB++;
        end
        checkOutput("edge1_count", 32'(cntB), 32'd1);
        reqB = 8'hF7; cntB = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1);
            if (validB) begin
                cntB++;
                checkOutput("edge2_code", 32'(codeB), 32'd3);
            end
        end
        reqB = 8'hFF;
        applyStimulus(4);
        checkOutput("edge2_count", 32'(cntB), 32'd1);

        // N=5: highest index 4 wins, then round-robin wraps from 0 to 4.
        ackC = 1'b1; rrC = 1'b0; reqC = 5'h00;
        applyStimulus(1);
        reqC = 5'h1F;
        collectC(5, 20);
        checkOutput("n5_fixed_count", 32'(gotN), 32'd5);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("n5_fixed_code%0d", i), 32'(gotCodes[i]), 32'(4 - i));
        applyStimulus(2);
        rrC = 1'b1; reqC = 5'h1B;
        applyStimulus(1);
        reqC = 5'h1F;
        collectC(1, 8);
        checkOutput("n5_rr_code2", 32'(gotCodes[0]), 32'd2);
        applyStimulus(2);
        reqC = 5'h1E;
        applyStimulus(1);
        reqC = 5'h1F;
        collectC(1, 8);
        checkOutput("n5_rr_code0", 32'(gotCodes[0]), 32'd0);
        applyStimulus(2);
        reqC = 5'h05;
        applyStimulus(1);
        reqC = 5'h1F;
        collectC(1, 8);
        checkOutput("n5_rr_wrap", 32'(gotCodes[0]), 32'd4);
        applyStimulus(8);

        // Randomized traffic on dutA against the reference model.
        cmpOn = 1'b1;
        for (int c = 0; c < 400; c++) begin
            reqA = 8'($urandom | $urandom);
            ackA = 1'($urandom_range(0, 1));
            enA  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) rrA = ~rrA;
            rst  = ($urandom_range(0, 99) == 0);
            applyStimulus(1);
            begin
                logic [7:0] mp;
                for (int i = 0; i < 8; i++) mp[i] = mPend[i];
                checkOutput($sformatf("rand%0d_pend", c), 32'(pendA), 32'(mp));
                checkOutput($sformatf("rand%0d_state", c),
                            {27'd0, validA, codeA, groupA, eoA} >> 0,
                            {27'd0, mValid, 3'(mCode), mGroup, mEo});
            end
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encoder_priority_arbiter_n.md
# encoder_priority_arbiter_n

Parametrised, registered successor to the 8-to-3 active-low priority encoder. It latches N active-low request lines into a pending register and selects one request by fixed or round-robin priority. The winning index is offered to a consumer through a valid/ack handshake. It sits between raw interrupt/request lines and the lab's sequencer logic, and keeps the active-low enable/group/cascade signals so that stages can be chained.

## Interface
- N, default 8: number of request lines, N ≥ 2; code width W = $clog2(N) (localparam).
- EDGE_MODE, default 0: 0 = level capture, 1 = capture on request assertion (high→low on req_i_).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- enable_in_  in  1  active-low enable; high = no capture, no grant, ack ignored.
- req_i_  in  N  active-low request lines.
- rr_mode  in  1  0 = fixed priority (highest index wins), 1 = round-robin.
- ack_i  in  1  consumer accepts code_o; only meaningful while valid_o = 1.
- code_o  out  W  granted index, true binary (not inverted).
- valid_o  out  1  code_o holds a live grant.
- pending_o  out  N  pending register, active-high.
- group_signal_  out  1  active-low: enabled and pending ≠ 0 (registered).
- enable_out_  out  1  active-low cascade: enabled, pending = 0, valid_o = 0 (registered).

## Operation
- Sample stage: smp ← ~req_i_ every cycle; smp_d ← smp.
- Set vector: enable_in_ low → level: smp; edge: smp & ~smp_d. enable_in_ high → 0. smp_d always tracks.
- pending ← (pending & ~clr) | set; clr = onehot(code_o) when valid_o & ack_i & ~enable_in_. Set wins on same bit.
- Level mode: a request still held low re-pends in the ack cycle. This is intended.
- Select: search pending downward from start index s with wrap. Fixed: s = N-1. RR: s = ptr.
- ptr resets to N-1. On accepted ack in rr_mode: ptr ← (code_o = 0) ? N-1 : code_o-1. Unchanged otherwise.
- FSM IDLE: enable_in_ low and pending ≠ 0 → register winner into code_o, valid_o ← 1, go OFFER.
- FSM OFFER, ack accepted: clear bit, valid_o ← 0, go IDLE.
- FSM OFFER, enable_in_ high: valid_o ← 0, go IDLE, pending untouched.
- FSM OFFER, otherwise: hold code_o/valid_o. Newer higher-priority requests never preempt.
- Reset values: pending 0, smp/smp_d 0, code_o 0, valid_o 0, ptr N-1, IDLE, group_signal_ 1, enable_out_ 1.
- rst mid-OFFER: the grant is dropped and pending is cleared; no ack is owed.

## Timing
- req_i_ low before edge t → smp at t, pending_o bit at t+1, valid_o/code_o at t+2 (if IDLE).
- Ack at edge a → valid_o 0 after a. Next grant no earlier than a+1 → max one grant per 2 cycles.
- group_signal_/enable_out_ reflect the previous cycle's pending/valid/enable (1-cycle lag).
- code_o stable for the whole time valid_o = 1.
- pending_o is a direct register output.

## Structure
- Package encoder_pkg:
  - state typedef (IDLE, OFFER).
  - onehot helper function.
- Sub-module priority_select:
  - Combinational, parameter N.
  - Inputs pending and start index.
  - Outputs index and found.
  - Wrap-around downward search.
- Top: sample regs, pending reg, ptr, FSM, cascade regs; target 150–250 lines.

## Test plan
- Reset: rst high 2 cycles with req_i_ = 0 → pending_o 0, valid_o 0, code_o 0, group_signal_ 1, enable_out_ 1.
  - Repeat rst high while valid_o = 1 → same values after the edge.
- Fixed, level, N=8: req_i_ = 8'hAB for one cycle (bits 6,4,2 low) → pending_o 8'h54.
  - Grants 6, 4, 2 with ack each time; pending_o 8'h14, 8'h04, 0.
  - group_signal_ returns to 1 and enable_out_ to 0.
- Round-robin: bits 7 and 1 held low, level, rr_mode = 1, ack on every offer → codes 7,1,7,1.
  - Same stimulus with rr_mode = 0 → 7,7,7.
- Edge mode: bit 3 held low for 10 cycles → exactly one grant of 3.
  - Release, then re-assert → second grant of 3.
- Handshake hold: grant 2 outstanding, no ack for 5 cycles, bit 7 asserted meanwhile → code_o stays 2.
  - After ack → next grant 7 two cycles later.
- Enable/width: enable_in_ high during OFFER with ack_i = 1 → valid_o 0 next cycle, pending unchanged.
  - enable_in_ low again → same code re-offered.
  - N=5: W=3, bit 4 wins; RR wraps 0→4.
